// File: rtl/divider_8b_seq.sv
// divider_8b_seq: sequential restoring divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
// Optional build macro DIVIDER_SELFCHECK_EN adds a multiply-back check of each
// non-zero-divisor result that drives chk_err; without it chk_err is tied low.
module divider_8b_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          chk_err
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_d;      // latched dividend, kept intact for the self-check
  logic [VW-1:0] r_v;      // latched divisor
  logic [VW-1:0] r_r;      // partial remainder; always < divisor between steps
  logic [DW-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic          r_dbz;

  logic [CW-1:0] w_idx;
  logic          w_bit;
  logic [VW:0]   w_rs;     // shifted remainder can reach 2V-1, hence VW+1 bits
  logic          w_ge;
  logic [VW-1:0] w_r_nxt;
  logic [DW-1:0] w_q_nxt;
  logic          w_last;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_idx   = LAST - r_cnt;
    w_bit   = r_d[w_idx];
    w_rs    = {r_r, w_bit};
    w_ge    = (w_rs >= {1'b0, r_v});
    w_r_nxt = w_ge ? VW'(w_rs - {1'b0, r_v}) : w_rs[VW-1:0];
    w_q_nxt = r_q;
    w_q_nxt[w_idx] = w_ge;
    w_last  = (r_cnt == LAST);
  end

  // Control FSM and datapath registers. A zero divisor still spends one
  // cycle in RUN so its result appears one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_v     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_d     <= dividend;
            r_v     <= divisor;
            r_r     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_v == '0) begin
            r_q     <= '1;
            r_r     <= r_d[VW-1:0];
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_r   <= w_r_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

`ifdef DIVIDER_SELFCHECK_EN
  logic                 r_chk;
  logic [DW+VW-1:0]     w_prod;
  logic                 w_chk_fail;

  // Multiply the final quotient back and compare with the latched dividend.
  always_comb begin
    w_prod     = (DW+VW)'(w_q_nxt) * (DW+VW)'(r_v) + (DW+VW)'(w_r_nxt);
    w_chk_fail = (w_prod != (DW+VW)'(r_d)) || (w_r_nxt >= r_v);
  end

  // Error flag is captured as the result is registered and drops with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= 1'b0;
    end else if ((r_state == RUN) && (r_v != '0) && w_last) begin
      r_chk <= w_chk_fail;
    end else if ((r_state == DONE) && out_ready) begin
      r_chk <= 1'b0;
    end
  end

  assign chk_err = r_chk;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_divider_8b_seq.sv
// Bench for divider_8b_seq: directed cases, backpressure, mid-operation reset
// and a full 256x16 operand sweep with random result stalls.
module tb_divider_8b_seq;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          chk_err;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  divider_8b_seq #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
    exp_t e;
    if (dv == '0) begin
      e.q = '1;
      e.r = dd[VW-1:0];
      e.z = 1'b1;
    end else begin
      e.q = dd / DW'(dv);
      e.r = VW'(dd % DW'(dv));
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair; the handshake happens on the next edge.
  task automatic send(input logic [DW-1:0] dd, input logic [VW-1:0] dv, input bit push);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    if (push) sb.push_back(model(dd, dv));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // Hold the result for 'stall' cycles, then pop the scoreboard and accept it.
  task automatic take(input string tag, input int stall);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb[0];
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      step();
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_q"}, 32'(quotient), 32'(e.q));
    end
    e = sb.pop_front();
    check({tag, "_q"}, 32'(quotient), 32'(e.q));
    check({tag, "_r"}, 32'(remainder), 32'(e.r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.z));
    check({tag, "_chk_err"}, 32'(chk_err), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    rst_n = 1'b1;
    step();

    send(8'd200, 4'd7, 1'b1);
    wait_out(8, "d200_7");
    check("d200_7_q_const", 32'(quotient), 32'd28);
    check("d200_7_r_const", 32'(remainder), 32'd4);
    take("d200_7", 0);

    send(8'd255, 4'd1, 1'b1);
    wait_out(8, "d255_1");
    take("d255_1", 0);

    send(8'd13, 4'd15, 1'b1);
    wait_out(8, "d13_15");
    take("d13_15", 0);

    send(8'hA6, 4'd0, 1'b1);
    wait_out(1, "dbz");
    check("dbz_q_const", 32'(quotient), 32'hFF);
    check("dbz_r_const", 32'(remainder), 32'h6);
    take("dbz", 0);

    // Backpressure with an ignored operand pulse, then a held operand that
    // must be taken only in the cycle after the output handshake.
    send(8'd100, 4'd3, 1'b1);
    wait_out(8, "bp");
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 1 || k == 2);
      dividend = 8'd9;
      divisor  = 4'd2;
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q", 32'(quotient), 32'(e.q));
      check("bp_r", 32'(remainder), 32'(e.r));
      check("bp_dbz", 32'(div_by_zero), 32'(e.z));
    end
    in_valid = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd6;
    out_ready = 1'b1;
    e = sb.pop_front();
    check("bp_final_q", 32'(quotient), 32'(e.q));
    check("bp_final_r", 32'(remainder), 32'(e.r));
    step();
    out_ready = 1'b0;
    check("bp_idle_after_handshake", 32'(in_ready), 32'd1);
    check("bp_no_valid_after_handshake", 32'(out_valid), 32'd0);
    sb.push_back(model(8'd50, 4'd6));
    step();
    in_valid = 1'b0;
    check("bp_new_accepted", 32'(in_ready), 32'd0);
    wait_out(8, "bp_next");
    take("bp_next", 0);

    // Reset during iteration 4 of 77/5; that result must never appear.
    send(8'd77, 4'd5, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rst_no_result", 32'(out_valid), 32'd0);
    send(8'd77, 4'd5, 1'b1);
    wait_out(8, "d77_5");
    check("d77_5_q_const", 32'(quotient), 32'd15);
    check("d77_5_r_const", 32'(remainder), 32'd2);
    take("d77_5", 0);

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        send(8'(i), 4'(j), 1'b1);
        wait_out(-1, $sformatf("sweep_%0d_%0d", i, j));
        take($sformatf("sweep_%0d_%0d", i, j), int'($urandom_range(0, 3)));
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
